serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor. Processes DIGIT bits of two WIDTH-bit operands per clock, using a ripple full-adder slice DIGIT bits wide. The carry is held in a register between cycles.
- Serves as the area-lean arithmetic unit for datapaths that can trade latency for logic.
- Valid/ready handshake on input and output.
- Adds subtract mode and signed-overflow detection to the single-bit full-add function.

Parameters:
- WIDTH, 8, operand and result width in bits; must be >= 1.
- DIGIT, 1, bits processed per cycle; must divide WIDTH exactly. N = WIDTH/DIGIT is the number of RUN cycles.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands; high only in IDLE
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- Cin  input  1  carry-in (Sub=0) or borrow-in (Sub=1)
- Sub  input  1  0 = add, 1 = subtract
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- Sum  output  WIDTH  result
- Cout  output  1  carry-out; in subtract mode 1 means no borrow
- Overflow  output  1  two's-complement signed overflow

Behaviour:
- Arithmetic
  - Sub=0: {Cout,Sum} = A + B + Cin.
  - Sub=1: {Cout,Sum} = A + ~B + ~Cin, i.e. A - B - Cin.
  - Carry register initialises to Cin XOR Sub at accept; the B operand register holds B XOR {WIDTH{Sub}}.
  - Overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Reset (async, any state)
  - state=IDLE; out_valid=0; Sum=0; Cout=0; Overflow=0; digit counter=0; carry register=0.
  - in_ready=1, since it decodes combinationally from IDLE.
  - An operation in progress is discarded with no partial output.
- FSM states: IDLE, RUN, DONE.
- IDLE
  - in_ready=1, out_valid=0.
  - in_valid=1 at a rising edge: capture A, B (conditioned by Sub), initial carry and Sub; clear counter; go to RUN.
  - in_valid=0: stay in IDLE.
- RUN
  - in_ready=0.
  - Each edge: add the low DIGIT bits of the A/B shift registers plus the carry register. Shift the DIGIT-bit sum into the MSB end of the result shift register. Update carry. Shift A/B right by DIGIT. Increment counter.
  - At the edge where counter = N-1:
    - load Sum from the completed shift value, plus Cout and Overflow;
    - set out_valid=1;
    - go to DONE.
  - in_valid is ignored throughout RUN.
- DONE
  - out_valid=1; Sum/Cout/Overflow held stable.
  - in_ready=0; in_valid ignored.
  - On an edge with out_ready=1: out_valid=0, go to IDLE. in_ready=1 in the following cycle.
  - No same-cycle accept of a new operation in DONE.
- Latency and throughput
  - out_valid is high in the cycle after the N-th edge following the accept edge, i.e. N cycles after accept.
  - Minimum issue interval: N+2 cycles, with out_ready held high.
- Boundaries
  - DIGIT=WIDTH: N=1, single RUN cycle.
  - WIDTH=1: degenerates to a registered full adder.
  - Counter width: clog2(N), minimum 1 bit. It must not wrap before reaching N-1.
  - Sum and Overflow depend only on captured values; input changes after accept have no effect.
  - Output registers update only at the RUN to DONE transition.

Test Plan:
- WIDTH=8, DIGIT=1, Sub=0: A=0x5A, B=0x33, Cin=0 → out_valid 8 cycles after accept; Sum=0x8D, Cout=0, Overflow=1.
- Sub=0: A=0xFF, B=0x01, Cin=0 → Sum=0x00, Cout=1, Overflow=0.
- Sub=0: A=0x7F, B=0x00, Cin=1 → Sum=0x80, Cout=0, Overflow=1.
- Sub=1:
  - A=0x10, B=0x20, Cin=0 → Sum=0xF0, Cout=0, Overflow=0.
  - A=0x80, B=0x01, Cin=0 → Sum=0x7F, Cout=1, Overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid/A/B → out_valid stays 1; Sum/Cout/Overflow stable; in_ready=0; no new capture. Then raise out_ready → IDLE next cycle.
- Reset mid-RUN: assert rst 3 cycles after accept → out_valid=0, Sum=0, in_ready=1 immediately. The next op, 0x01+0x02 with Cin=0, gives Sum=0x03.
- WIDTH=16, DIGIT=4: A=0xFFFF, B=0x0001, Cin=0 → out_valid 4 cycles after accept; Sum=0x0000, Cout=1, Overflow=0.
- Back-to-back random ops with out_ready=1 → issue interval 10 cycles at WIDTH=8, DIGIT=1; every result matches a reference model.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: digit-serial add/subtract, DIGIT bits per cycle, valid/ready on both sides
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow
);
  localparam int N = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt;
  logic carry;
  logic [CW-1:0] cnt;
  logic [DIGIT:0] c;
  logic [DIGIT-1:0] s;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  // c[DIGIT-1] is the carry into the top bit of this digit, needed for overflow on the last digit
  always_comb begin
    c = {{DIGIT{1'b0}}, carry};
    s = '0;
    for (int i = 0; i < DIGIT; i++) begin
      s[i] = a_sr[i] ^ b_sr[i] ^ c[i];
      c[i+1] = (a_sr[i] & b_sr[i]) | (c[i] & (a_sr[i] ^ b_sr[i]));
    end
  end
  assign res_nxt = WIDTH'({s, res_sr} >> DIGIT);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sr <= '0;
      b_sr <= '0;
      res_sr <= '0;
      carry <= 1'b0;
      cnt <= '0;
      Sum <= '0;
      Cout <= 1'b0;
      Overflow <= 1'b0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        a_sr <= A;
        b_sr <= B ^ {WIDTH{Sub}};
        carry <= Cin ^ Sub;
        cnt <= '0;
        state <= RUN;
      end
    end else if (state == RUN) begin
      a_sr <= a_sr >> DIGIT;
      b_sr <= b_sr >> DIGIT;
      res_sr <= res_nxt;
      carry <= c[DIGIT];
      cnt <= cnt + 1'b1;
      if (cnt == LAST) begin
        Sum <= res_nxt;
        Cout <= c[DIGIT];
        Overflow <= c[DIGIT] ^ c[DIGIT-1];
        state <= DONE;
      end
    end else if (out_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: vectors, corner sequences and random ops checked against an arithmetic model
module tb_serial_adder;
  logic clk = 0, rst = 1, Cin = 0, Sub = 0, ordy = 1;
  logic [15:0] A = 0, B = 0, sum_b;
  logic [7:0] sum_a, sum_c;
  logic [2:0] iv = 0, vld, rdy, co, ovf;
  int tests = 0, fails = 0, cyc = 0;

  typedef struct {
    logic [7:0] a, b;
    logic cin, sub;
    logic [7:0] s;
    logic co, ov;
  } vec_t;
  vec_t tbl[5];

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_a (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rdy[0]),
    .A(A[7:0]), .B(B[7:0]), .Cin(Cin), .Sub(Sub), .out_valid(vld[0]), .out_ready(ordy),
    .Sum(sum_a), .Cout(co[0]), .Overflow(ovf[0]));
  serial_adder #(.WIDTH(16), .DIGIT(4)) u_b (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rdy[1]),
    .A(A), .B(B), .Cin(Cin), .Sub(Sub), .out_valid(vld[1]), .out_ready(ordy),
    .Sum(sum_b), .Cout(co[1]), .Overflow(ovf[1]));
  serial_adder #(.WIDTH(8), .DIGIT(8)) u_c (.clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(rdy[2]),
    .A(A[7:0]), .B(B[7:0]), .Cin(Cin), .Sub(Sub), .out_valid(vld[2]), .out_ready(ordy),
    .Sum(sum_c), .Cout(co[2]), .Overflow(ovf[2]));

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [15:0] sum_of(int d);
    return d == 0 ? {8'h0, sum_a} : d == 1 ? sum_b : {8'h0, sum_c};
  endfunction

  function automatic void model(int w, logic [15:0] a, logic [15:0] b, logic cin, logic sub,
                                output logic [15:0] s, output logic c, output logic v);
    longint m = longint'(1) << w;
    longint ua = a & (m - 1);
    longint ub = b & (m - 1);
    longint ci = cin;
    longint sa = ua >= m / 2 ? ua - m : ua;
    longint sb = ub >= m / 2 ? ub - m : ub;
    longint r = sub ? ua - ub - ci : ua + ub + ci;
    longint sr = sub ? sa - sb - ci : sa + sb + ci;
    c = sub ? r >= 0 : r >= m;
    s = 16'((r + 2 * m) % m);
    v = sr < -(m / 2) || sr >= m / 2;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic op(int d, logic [15:0] a, logic [15:0] b, logic cin, logic sub,
                    output logic [15:0] s, output logic c, output logic v, output int lat, output int acc);
    int t = 0;
    @(negedge clk);
    while (!rdy[d] && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("idle_wait", rdy[d], 1);
    A = a; B = b; Cin = cin; Sub = sub; iv[d] = 1;
    @(posedge clk);
    #1 acc = cyc;
    iv[d] = 0;
    A = 16'($urandom); B = 16'($urandom); Cin = ~cin; Sub = ~sub;
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!vld[d] && lat < 40);
    s = sum_of(d); c = co[d]; v = ovf[d];
  endtask

  initial begin
    logic [15:0] s, es, ra, rb;
    logic c, v, ec, ev, rc, rs;
    int lat, acc, prev;
    tbl[0] = '{8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[3] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
    tbl[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    #3;
    chk("rst_out_valid", vld, 0);
    chk("rst_in_ready", rdy, 3'b111);
    chk("rst_sum", sum_a, 0);
    chk("rst_cout", co, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk) rst = 0;
    for (int i = 0; i < 5; i++) begin
      op(0, 16'(tbl[i].a), 16'(tbl[i].b), tbl[i].cin, tbl[i].sub, s, c, v, lat, acc);
      chk($sformatf("vec%0d_sum", i), s, 16'(tbl[i].s));
      chk($sformatf("vec%0d_cout", i), c, tbl[i].co);
      chk($sformatf("vec%0d_ovf", i), v, tbl[i].ov);
      chk($sformatf("vec%0d_latency", i), lat, 8);
      op(2, 16'(tbl[i].a), 16'(tbl[i].b), tbl[i].cin, tbl[i].sub, s, c, v, lat, acc);
      chk($sformatf("n1_vec%0d_sum", i), s, 16'(tbl[i].s));
      chk($sformatf("n1_vec%0d_cout_ovf", i), {c, v}, {tbl[i].co, tbl[i].ov});
      chk($sformatf("n1_vec%0d_latency", i), lat, 1);
    end
    op(1, 16'hFFFF, 16'h0001, 0, 0, s, c, v, lat, acc);
    chk("w16_sum", s, 16'h0000);
    chk("w16_cout", c, 1);
    chk("w16_ovf", v, 0);
    chk("w16_latency", lat, 4);
    for (int i = 0; i < 10; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      op(1, ra, rb, rc, rs, s, c, v, lat, acc);
      model(16, ra, rb, rc, rs, es, ec, ev);
      chk($sformatf("w16_rand%0d", i), {s, c, v}, {es, ec, ev});
    end
    ordy = 0;
    op(0, 16'h5A, 16'h33, 0, 0, s, c, v, lat, acc);
    chk("bp_sum", s, 16'h8D);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      iv[0] = ~iv[0]; A = 16'($urandom); B = 16'($urandom); Sub = ~Sub;
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_hold", k), {vld[0], rdy[0], sum_a, co[0], ovf[0]}, {1'b1, 1'b0, 8'h8D, 1'b0, 1'b1});
    end
    @(negedge clk);
    iv[0] = 0; ordy = 1;
    @(posedge clk);
    #1;
    chk("bp_release", {rdy[0], vld[0], sum_a}, {1'b1, 1'b0, 8'h8D});
    @(negedge clk);
    A = 16'hC3; B = 16'h11; Cin = 0; Sub = 0; iv[0] = 1;
    @(posedge clk);
    #1 iv[0] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    #1;
    chk("midrun_rst", {vld[0], rdy[0], sum_a}, {1'b0, 1'b1, 8'h00});
    @(negedge clk) rst = 0;
    op(0, 16'h01, 16'h02, 0, 0, s, c, v, lat, acc);
    chk("after_rst_sum", s, 16'h03);
    chk("after_rst_latency", lat, 8);
    prev = 0;
    for (int k = 0; k < 20; k++) begin
      ra = 16'($urandom_range(0, 255)); rb = 16'($urandom_range(0, 255));
      rc = 1'($urandom); rs = 1'($urandom);
      op(0, ra, rb, rc, rs, s, c, v, lat, acc);
      model(8, ra, rb, rc, rs, es, ec, ev);
      chk($sformatf("rand%0d", k), {s, c, v, lat}, {es, ec, ev, 8});
      if (k > 0) chk($sformatf("interval%0d", k), acc - prev, 10);
      prev = acc;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
